// File: rtl/stack_down_lane_sync_buffer.sv
// Purpose: per-lane stack-down receive FIFOs released to the PE as lane-aligned words, framing-checked (SOD/MOD/EOD).
// Latency: a word written at edge t is presented on buf__pe__valid after edge t+1; one word per cycle thereafter.
// Backpressure: lane__std__ready drops per lane at PF_MARGIN free entries (registered); pe__buf__ready stalls the output slot.
// Ports: clk, reset_poweron (sync, active high); cfg__lane_enable lane mask (latched at message start);
//   std__lane__valid/cntl/data lane write side, lane__std__ready per-lane ready;
//   buf__pe__valid/cntl/data/lane_mask + pe__buf__ready aligned output; buf__sys__cntl_err, buf__sys__overflow sticky flags.
// Option: define STACK_DOWN_LANE_SYNC_BUF_STATS_EN to add buf__sys__msg_count and buf__sys__stall_count.
module stack_down_lane_sync_buffer #(
  parameter int NUM_LANES  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PF_MARGIN  = 2
) (
  input  logic                             clk,
  input  logic                             reset_poweron,
  input  logic [NUM_LANES-1:0]             cfg__lane_enable,
  input  logic [NUM_LANES-1:0]             std__lane__valid,
  input  logic [2*NUM_LANES-1:0]           std__lane__cntl,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  std__lane__data,
  output logic [NUM_LANES-1:0]             lane__std__ready,
  output logic                             buf__pe__valid,
  output logic [1:0]                       buf__pe__cntl,
  output logic [DATA_WIDTH*NUM_LANES-1:0]  buf__pe__data,
  output logic [NUM_LANES-1:0]             buf__pe__lane_mask,
  input  logic                             pe__buf__ready,
  output logic                             buf__sys__cntl_err,
  output logic                             buf__sys__overflow
`ifdef STACK_DOWN_LANE_SYNC_BUF_STATS_EN
  ,
  output logic [31:0]                      buf__sys__msg_count,
  output logic [31:0]                      buf__sys__stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - PF_MARGIN - 1);

  localparam logic [1:0] C_MOD     = 2'b00;
  localparam logic [1:0] C_SOD     = 2'b01;
  localparam logic [1:0] C_EOD     = 2'b10;
  localparam logic [1:0] C_SOD_EOD = 2'b11;

  typedef enum logic {WAIT_SOD, STREAM} state_t;
  state_t state_q, state_d;

  // Each entry stores {cntl, data}.
  logic [DATA_WIDTH+1:0] mem     [NUM_LANES][DEPTH];
  logic [AW-1:0]         wr_ptr  [NUM_LANES];
  logic [AW-1:0]         rd_ptr  [NUM_LANES];
  logic [CW-1:0]         count   [NUM_LANES];
  logic [CW-1:0]         count_d [NUM_LANES];

  logic [NUM_LANES-1:0]            active_mask, pop, wr_en, wr_full;
  logic                            heads_ok, disagree, lead_found, slot_free;
  logic                            load, pop_all, err_set;
  logic [1:0]                      lead_cntl, load_cntl;
  logic [DATA_WIDTH*NUM_LANES-1:0] load_data;

  // Between messages the live enable decides which lanes take part; inside a
  // message the mask latched with the SOD word does.
  assign active_mask = (state_q == WAIT_SOD) ? cfg__lane_enable : buf__pe__lane_mask;
  assign slot_free   = !buf__pe__valid || pe__buf__ready;
  assign pop         = pop_all ? active_mask : '0;

  // Head alignment: every active lane non-empty; cntl taken from the lowest active lane.
  always_comb begin
    heads_ok   = |active_mask;
    disagree   = 1'b0;
    lead_found = 1'b0;
    lead_cntl  = C_MOD;
    load_data  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (active_mask[i]) begin
        if (count[i] == '0) heads_ok = 1'b0;
        load_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]][DATA_WIDTH-1:0];
        if (!lead_found) begin
          lead_cntl  = mem[i][rd_ptr[i]][DATA_WIDTH +: 2];
          lead_found = 1'b1;
        end else if (mem[i][rd_ptr[i]][DATA_WIDTH +: 2] != lead_cntl) begin
          disagree = 1'b1;
        end
      end
    end
  end

  // Framing FSM: next state and release control.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    pop_all   = 1'b0;
    err_set   = 1'b0;
    load_cntl = lead_cntl;
    if (heads_ok) begin
      err_set = disagree;
      case (state_q)
        WAIT_SOD: begin
          if (lead_cntl == C_SOD || lead_cntl == C_SOD_EOD) begin
            if (slot_free) begin
              load    = 1'b1;
              pop_all = 1'b1;
              if (lead_cntl == C_SOD) state_d = STREAM;
            end
          end else begin
            // Stray MOD/EOD outside a message: dropped without using the slot.
            pop_all = 1'b1;
            err_set = 1'b1;
          end
        end
        STREAM: begin
          if (slot_free) begin
            load    = 1'b1;
            pop_all = 1'b1;
            if (lead_cntl == C_EOD) begin
              state_d = WAIT_SOD;
            end else if (lead_cntl != C_MOD) begin
              // A new SOD inside a message closes the current one.
              err_set   = 1'b1;
              load_cntl = C_EOD;
              state_d   = WAIT_SOD;
            end
          end
        end
        default: state_d = WAIT_SOD;
      endcase
    end
  end

  // Write side: a full lane may still accept when it pops on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_full[i] = std__lane__valid[i] && active_mask[i] && (count[i] == FULL_CNT) && !pop[i];
      wr_en[i]   = std__lane__valid[i] && active_mask[i] && !wr_full[i];
      count_d[i] = count[i] + CW'(wr_en[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) state_q <= WAIT_SOD;
    else               state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      buf__pe__valid     <= 1'b0;
      buf__pe__cntl      <= 2'b00;
      buf__pe__data      <= '0;
      buf__pe__lane_mask <= '0;
      buf__sys__cntl_err <= 1'b0;
      buf__sys__overflow <= 1'b0;
      lane__std__ready   <= '1;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (load) begin
        buf__pe__valid     <= 1'b1;
        buf__pe__cntl      <= load_cntl;
        buf__pe__data      <= load_data;
        buf__pe__lane_mask <= active_mask;
      end else if (pe__buf__ready) begin
        buf__pe__valid <= 1'b0;
      end
      if (err_set)  buf__sys__cntl_err <= 1'b1;
      if (|wr_full) buf__sys__overflow <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i]            <= count_d[i];
        lane__std__ready[i] <= (count_d[i] <= READY_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= {std__lane__cntl[2*i +: 2], std__lane__data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

`ifdef STACK_DOWN_LANE_SYNC_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      buf__sys__msg_count   <= '0;
      buf__sys__stall_count <= '0;
    end else begin
      // cntl[1] set means EOD or SOD_EOD: the word closes a message.
      if (buf__pe__valid && pe__buf__ready && buf__pe__cntl[1] && (buf__sys__msg_count != '1))
        buf__sys__msg_count <= buf__sys__msg_count + 32'd1;
      if (buf__pe__valid && !pe__buf__ready && (buf__sys__stall_count != '1))
        buf__sys__stall_count <= buf__sys__stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_down_lane_sync_buffer.sv
module tb_stack_down_lane_sync_buffer;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int BW = NL * DW;
  localparam int NW = 48;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic [NL-1:0] cfg, valid, ready, lmask;
  logic [2*NL-1:0] cntl;
  logic [BW-1:0] data, odata;
  logic          ovalid, pe_ready, err, ovf;
  logic [1:0]    ocntl;
`ifdef STACK_DOWN_LANE_SYNC_BUF_STATS_EN
  logic [31:0]   msg_count, stall_count;
`endif

  always #5 clk = ~clk;

  stack_down_lane_sync_buffer #(.NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH(8), .PF_MARGIN(2)) dut (
    .clk(clk), .reset_poweron(reset_poweron), .cfg__lane_enable(cfg),
    .std__lane__valid(valid), .std__lane__cntl(cntl), .std__lane__data(data),
    .lane__std__ready(ready), .buf__pe__valid(ovalid), .buf__pe__cntl(ocntl),
    .buf__pe__data(odata), .buf__pe__lane_mask(lmask), .pe__buf__ready(pe_ready),
    .buf__sys__cntl_err(err), .buf__sys__overflow(ovf)
`ifdef STACK_DOWN_LANE_SYNC_BUF_STATS_EN
    , .buf__sys__msg_count(msg_count), .buf__sys__stall_count(stall_count)
`endif
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic v, input logic [1:0] c, input logic [31:0] d);
    valid[i]          = v;
    cntl[2*i +: 2]    = c;
    data[i*DW +: DW]  = d;
  endtask

  task automatic drive_all(input logic [NL-1:0] m, input logic [1:0] c, input logic [31:0] base);
    for (int i = 0; i < NL; i++) set_lane(i, m[i], c, base + 32'(i));
  endtask

  function automatic logic [BW-1:0] word(input logic [31:0] base, input logic [NL-1:0] m);
    logic [BW-1:0] w;
    w = '0;
    for (int i = 0; i < NL; i++) if (m[i]) w[i*DW +: DW] = base + 32'(i);
    return w;
  endfunction

  task automatic do_reset();
    reset_poweron = 1'b1;
    valid = '0;
    nclk();
    reset_poweron = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] c, input logic [BW-1:0] d, input logic [NL-1:0] m);
    chk({tag, "_valid"}, ovalid, 1);
    chk({tag, "_cntl"}, ocntl, c);
    chk({tag, "_data"}, odata, d);
    chk({tag, "_mask"}, lmask, m);
  endtask

  // Reference model storage for the randomized run.
  logic [1:0]    rc [NL][NW];
  logic [31:0]   rd [NL][NW];
  logic [1:0]    eq_c [$];
  logic [BW-1:0] eq_d [$];
  logic [1:0]    c, c0;
  logic [BW-1:0] w;
  bit            exp_err, in_msg, dis, busy;
  int            ix [NL];
  int            cyc, r;

  initial begin
    reset_poweron = 1'b1; cfg = 4'hF; valid = '0; cntl = '0; data = '0; pe_ready = 1'b1;
    nclk(); nclk();
    reset_poweron = 1'b0;

    // Reset state
    chk("rst_ready", ready, 4'hF);
    chk("rst_valid", ovalid, 0);
    chk("rst_cntl", ocntl, 0);
    chk("rst_data", odata, 0);
    chk("rst_mask", lmask, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);

    // Basic message SOD,MOD,MOD,EOD on all four lanes
    for (int k = 0; k < 7; k++) begin
      if (k == 1 || k == 6) chk("basic_idle", ovalid, 0);
      if (k >= 2 && k <= 5)
        chk_out("basic", (k == 2) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00,
                word(32'h1000 + 32'(k-2)*32'h100, 4'hF), 4'hF);
      if (k < 4) drive_all(4'hF, (k == 0) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00, 32'h1000 + 32'(k)*32'h100);
      else valid = '0;
      nclk();
    end
    chk("basic_err", err, 0);
    chk("basic_ovf", ovf, 0);

    // Lane 3 lags by three cycles
    for (int k = 0; k < 8; k++) begin
      if (k >= 1 && k <= 4) chk("skew_wait", ovalid, 0);
      if (k == 5) chk_out("skew0", 2'b01, word(32'h2000, 4'hF), 4'hF);
      if (k == 6) chk_out("skew1", 2'b10, word(32'h2010, 4'hF), 4'hF);
      if (k == 7) chk("skew_idle", ovalid, 0);
      for (int i = 0; i < 3; i++)
        if (k < 2) set_lane(i, 1'b1, (k == 0) ? 2'b01 : 2'b10, 32'h2000 + 32'(k)*16 + 32'(i));
        else valid[i] = 1'b0;
      if (k == 3 || k == 4) set_lane(3, 1'b1, (k == 3) ? 2'b01 : 2'b10, 32'h2000 + 32'(k-3)*16 + 3);
      else valid[3] = 1'b0;
      nclk();
    end

    // Backpressure and overflow on lane 0
    pe_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k >= 1) chk("bp_ready0", ready[0], ((k > 8 ? 8 : k) <= 5) ? 1 : 0);
      if (k == 8) chk("bp_no_ovf", ovf, 0);
      if (k == 9) chk("bp_ovf", ovf, 1);
      if (k == 9) chk("bp_no_release", ovalid, 0);
      if (k < 9) set_lane(0, 1'b1, (k == 0) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00, 32'h3000 + 32'(k)*16);
      else valid = '0;
      nclk();
    end
    for (int k = 0; k < 8; k++) begin
      valid[0] = 1'b0;
      for (int i = 1; i < NL; i++)
        set_lane(i, 1'b1, (k == 0) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00, 32'h3000 + 32'(k)*16 + 32'(i));
      nclk();
    end
    valid = '0;
    pe_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk_out("bp_drain", (j == 0) ? 2'b01 : (j == 7) ? 2'b10 : 2'b00, word(32'h3000 + 32'(j)*16, 4'hF), 4'hF);
      nclk();
    end
    chk("bp_drained", ovalid, 0);

    // Framing errors on lanes 0/1
    do_reset();
    chk("rst2_ovf", ovf, 0);
    cfg = 4'h3;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) chk("frm_err_clear", err, 0);
      if (k == 2 || k == 4) chk("frm_discard", ovalid, 0);
      if (k >= 2) chk("frm_err", err, 1);
      if (k == 6) chk_out("frm_sod", 2'b01, word(32'h4040, 4'h3), 4'h3);
      if (k == 7) chk_out("frm_forced_eod", 2'b10, word(32'h4050, 4'h3), 4'h3);
      if (k == 8) chk_out("frm_sod_eod", 2'b11, word(32'h4060, 4'h3), 4'h3);
      if (k >= 9) chk("frm_tail_discard", ovalid, 0);
      valid = '0;
      case (k)
        0: begin c0 = 2'b00; c = 2'b00; end
        2: begin c0 = 2'b00; c = 2'b01; end
        4, 5: begin c0 = 2'b01; c = 2'b01; end
        6: begin c0 = 2'b11; c = 2'b11; end
        7: begin c0 = 2'b00; c = 2'b00; end
        default: begin c0 = 2'bxx; c = 2'bxx; end
      endcase
      if (c0 !== 2'bxx) begin
        set_lane(0, 1'b1, c0, 32'h4000 + 32'(k)*16);
        set_lane(1, 1'b1, c, 32'h4000 + 32'(k)*16 + 1);
      end
      nclk();
    end

    // Mask latched at SOD while cfg changes mid-message
    do_reset();
    cfg = 4'h3;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) cfg = 4'hF;
      if (k >= 2 && k <= 5)
        chk_out("mask_hold", (k == 2) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00, word(32'h5000 + 32'(k-2)*16, 4'h3), 4'h3);
      if (k == 6 || k == 7) chk("mask_idle", ovalid, 0);
      if (k == 8) chk_out("mask_new", 2'b11, word(32'h5060, 4'hF), 4'hF);
      if (k < 4) drive_all(4'hF, (k == 0) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00, 32'h5000 + 32'(k)*16);
      else if (k == 6) drive_all(4'hF, 2'b11, 32'h5060);
      else valid = '0;
      nclk();
    end
    chk("mask_err", err, 0);

    // Reset mid-message with three words buffered behind the slot
    do_reset();
    pe_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_all(4'hF, (k == 0) ? 2'b01 : 2'b00, 32'h6000 + 32'(k)*16);
      nclk();
    end
`ifdef STACK_DOWN_LANE_SYNC_BUF_STATS_EN
    chk("stat_stall", stall_count, 2);
`endif
    do_reset();
    chk("mrst_valid", ovalid, 0);
    chk("mrst_ready", ready, 4'hF);
    chk("mrst_mask", lmask, 0);
`ifdef STACK_DOWN_LANE_SYNC_BUF_STATS_EN
    chk("mrst_stall", stall_count, 0);
    chk("mrst_msg", msg_count, 0);
`endif
    pe_ready = 1'b1;
    drive_all(4'hF, 2'b11, 32'h7000);
    nclk();
    valid = '0;
    nclk();
    chk_out("mrst_fresh", 2'b11, word(32'h7000, 4'hF), 4'hF);
    nclk();
    chk("mrst_fresh_done", ovalid, 0);
`ifdef STACK_DOWN_LANE_SYNC_BUF_STATS_EN
    chk("stat_msg", msg_count, 1);
`endif

    // Randomized traffic against the word-level framing model
    do_reset();
    cfg = 4'hF;
    for (int j = 0; j < NW; j++) begin
      r = $urandom_range(0, 9);
      c = (r < 2) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
      for (int i = 0; i < NL; i++) begin
        rc[i][j] = c;
        rd[i][j] = $urandom;
      end
      if ($urandom_range(0, 9) == 0) rc[$urandom_range(0, NL-1)][j] = 2'($urandom);
    end
    in_msg = 1'b0; exp_err = 1'b0;
    for (int j = 0; j < NW; j++) begin
      c0 = rc[0][j];
      dis = 1'b0;
      for (int i = 0; i < NL; i++) begin
        if (rc[i][j] != c0) dis = 1'b1;
        w[i*DW +: DW] = rd[i][j];
      end
      if (dis) exp_err = 1'b1;
      if (!in_msg) begin
        if (c0 == 2'b01) begin eq_c.push_back(2'b01); eq_d.push_back(w); in_msg = 1'b1; end
        else if (c0 == 2'b11) begin eq_c.push_back(2'b11); eq_d.push_back(w); end
        else exp_err = 1'b1;
      end else begin
        if (c0 == 2'b00) begin eq_c.push_back(2'b00); eq_d.push_back(w); end
        else begin
          if (c0 != 2'b10) exp_err = 1'b1;
          eq_c.push_back(2'b10); eq_d.push_back(w); in_msg = 1'b0;
        end
      end
    end
    for (int i = 0; i < NL; i++) ix[i] = 0;
    cyc = 0; busy = 1'b1;
    while (busy && cyc < 3000) begin
      pe_ready = ($urandom_range(0, 3) != 0);
      if (ovalid && pe_ready) begin
        if (eq_c.size() == 0) chk("rnd_extra_word", ovalid, 0);
        else begin
          chk("rnd_cntl", ocntl, eq_c[0]);
          chk("rnd_data", odata, eq_d[0]);
          void'(eq_c.pop_front());
          void'(eq_d.pop_front());
        end
      end
      for (int i = 0; i < NL; i++) begin
        if (ix[i] < NW && ready[i] && $urandom_range(0, 2) != 0) begin
          set_lane(i, 1'b1, rc[i][ix[i]], rd[i][ix[i]]);
          ix[i]++;
        end else valid[i] = 1'b0;
      end
      nclk();
      cyc++;
      busy = (eq_c.size() != 0);
      for (int i = 0; i < NL; i++) if (ix[i] < NW) busy = 1'b1;
    end
    valid = '0;
    chk("rnd_timeout", busy, 0);
    chk("rnd_left", eq_c.size(), 0);
    nclk(); nclk();
    chk("rnd_no_extra", ovalid, 0);
    chk("rnd_err", err, exp_err);
    chk("rnd_ovf", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
